instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the moka_rv32 core. Holds the fetch PC, issues one-outstanding word requests to instruction memory, and registers the returned instruction. The registered word drives the decoder and the `xin` input of the immediate extender. Taken branches and jumps are accepted through a redirect port, and any in-flight response belonging to the old path is squashed.

## Interface
Parameters
- `DATA_WIDTH`, 32: width of instruction, address and PC.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `en`  in  1  stage enable. When low, no new request is issued and HOLD does not advance.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  DATA_WIDTH  request address (word-aligned).
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response valid; exactly one per accepted request, at least 1 cycle later.
- `imem_rdata`  in  DATA_WIDTH  response instruction word.
- `redirect`  in  1  taken branch/jump; sampled only when `en`=1.
- `redirect_pc`  in  DATA_WIDTH  new fetch address.
- `id_ready`  in  1  downstream consumes `instr` this cycle.
- `instr`  out  DATA_WIDTH  registered instruction, goes to decode and the extender `xin`.
- `instr_valid`  out  1  `instr`/`pc` are valid.
- `pc`  out  DATA_WIDTH  address of `instr`.
- `pc_plus4`  out  DATA_WIDTH  `pc`+4, modulo 2^32.
- `misaligned_fault`  out  1  sticky; set when `redirect_pc[1:0]`≠0.

## Operation
- Fetch PC register `fpc`; drop flag `drop`; states REQ, WAIT, HOLD, FAULT.
- **Reset values:** `fpc`=`RESET_PC`, state REQ, `drop`=0, `imem_req`=0 while `rstn`=0, `imem_addr`=`RESET_PC`, `instr`=0, `instr_valid`=0, `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4, `misaligned_fault`=0.
- **REQ:**
  - `imem_req` = `en`; `imem_addr` = `fpc`.
  - When `imem_req`&`imem_ready`, go to WAIT.
- **WAIT:**
  - `imem_req`=0. Responses are always accepted, regardless of `en`.
  - On `imem_rvalid` with `drop`=1: clear `drop`, go to REQ.
  - On `imem_rvalid` with `drop`=0: `instr`←`imem_rdata`, `pc`←`fpc`, `pc_plus4`←`fpc`+4, `instr_valid`←1, go to HOLD.
- **HOLD:**
  - `instr_valid`=1 and `instr` stable.
  - On `en`&`id_ready`: `fpc`←`fpc`+4 (wraps 0xFFFF_FFFC→0x0000_0000), `instr_valid`←0, go to REQ.
- **Redirect** (`en`&`redirect`) has priority over every other transition.
  - `instr_valid`←0.
  - If `redirect_pc[1:0]`≠0: `misaligned_fault`←1 and go to FAULT. An outstanding response is still absorbed, then discarded.
  - Otherwise `fpc`←`redirect_pc`, with the next state set as follows:
    - REQ, request not accepted this cycle: stay in REQ (new address next cycle).
    - REQ, request accepted this cycle: go to WAIT with `drop`←1.
    - WAIT, no `imem_rvalid` this cycle: stay in WAIT with `drop`←1.
    - WAIT, `imem_rvalid` this cycle: discard the response, go to REQ.
    - HOLD: go to REQ.
- **FAULT:** `imem_req`=0 and `instr_valid`=0. Left only by reset.
- At most one outstanding request at any time.

## Timing
- Zero-wait memory (`imem_ready`=1, `imem_rvalid` one cycle after accept) with `id_ready`=1:
  - REQ at cycle n, response at n+1, `instr_valid` at n+2, REQ again at n+3.
  - Steady throughput is one instruction per 3 cycles.
- Redirect to new request: `imem_req` with `redirect_pc` is on the cycle after redirect (from REQ/HOLD). From WAIT it follows the cycle after the old response arrives.
- `instr` changes only on entry to HOLD and holds while `instr_valid`=1.
- Asynchronous reset mid-transaction returns all state to reset values immediately. A response arriving after reset release, before a new request is accepted, must be ignored (state REQ ignores `imem_rvalid`).
- `en`=0 in HOLD freezes all outputs. `en`=0 in WAIT still captures the response into HOLD.

## Test plan
- Reset release, `RESET_PC`=0, zero-wait memory returning `addr`^32'hA5A5_0000 → `imem_addr` sequence 0,4,8. `instr`=0xA5A5_0000, 0xA5A5_0004 with matching `pc`/`pc_plus4`, a valid pulse every 3 cycles.
- `id_ready`=0 for 5 cycles in HOLD → `instr`, `pc` and `instr_valid` stable, no `imem_req`. Release → next address `pc`+4.
- Redirect to 0x100 in WAIT with memory latency 3 → old response not presented, next `imem_addr`=0x100, `instr_valid` first rises with `pc`=0x100.
- Redirect to 0x200 in the same cycle as request accept at 0x8 → 0x8 response dropped, next request 0x200.
- Redirect to 0x102 → `misaligned_fault`=1 sticky, no further `imem_req`. Reset clears it and restarts at `RESET_PC`.
- Redirect to 0xFFFF_FFFC, consume → `pc_plus4`=0, next `imem_addr`=0x0000_0000.

Source files
------------

// File: rtl/instr_fetch.sv
// Fetch stage for moka_rv32: holds the fetch PC, keeps one word request in flight,
// registers the returned instruction and squashes responses from a redirected path.
module instr_fetch #(
   parameter int unsigned          DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC  = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  en,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  redirect,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   input  logic                  id_ready,
   output logic [DATA_WIDTH-1:0] instr,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] pc,
   output logic [DATA_WIDTH-1:0] pc_plus4,
   output logic                  misaligned_fault
);

   localparam logic [1:0] REQ   = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;
   localparam logic [1:0] FAULT = 2'd3;

   localparam logic [DATA_WIDTH-1:0] WORD_STEP = DATA_WIDTH'(32'd4);

   logic [1:0]            state_r, state_s;
   logic [DATA_WIDTH-1:0] fpc_r, fpc_s;
   logic                  drop_r, drop_s;
   logic                  valid_s;
   logic                  fault_s;
   logic                  load_s;
   logic                  accept_s;
   logic                  redir_s;
   logic                  bad_pc_s;

   // rstn gates the request so nothing is issued while reset is held
   assign imem_req  = rstn & en & (state_r == REQ);
   assign imem_addr = fpc_r;
   assign accept_s  = imem_req & imem_ready;
   assign redir_s   = en & redirect & (state_r != FAULT);
   assign bad_pc_s  = (redirect_pc[1:0] != 2'b00);

   // Next-state logic; a redirect overrides every other transition
   always_comb begin
      state_s = state_r;
      fpc_s   = fpc_r;
      drop_s  = drop_r;
      valid_s = instr_valid;
      fault_s = misaligned_fault;
      load_s  = 1'b0;
      if (redir_s) begin
         valid_s = 1'b0;
         if (bad_pc_s) begin
            fault_s = 1'b1;
            drop_s  = 1'b0;
            state_s = FAULT;
         end else begin
            fpc_s = redirect_pc;
            case (state_r)
               REQ: begin
                  if (accept_s) begin
                     state_s = WAIT;
                     drop_s  = 1'b1;
                  end else begin
                     state_s = REQ;
                  end
               end
               WAIT: begin
                  if (imem_rvalid) begin
                     state_s = REQ;
                     drop_s  = 1'b0;
                  end else begin
                     drop_s  = 1'b1;
                  end
               end
               HOLD:    state_s = REQ;
               default: state_s = state_r;
            endcase
         end
      end else begin
         case (state_r)
            REQ: begin
               if (accept_s) begin
                  state_s = WAIT;
               end else begin
                  state_s = REQ;
               end
            end
            WAIT: begin
               if (imem_rvalid && drop_r) begin
                  drop_s  = 1'b0;
                  state_s = REQ;
               end else if (imem_rvalid) begin
                  load_s  = 1'b1;
                  valid_s = 1'b1;
                  state_s = HOLD;
               end else begin
                  state_s = WAIT;
               end
            end
            HOLD: begin
               if (en && id_ready) begin
                  fpc_s   = fpc_r + WORD_STEP;
                  valid_s = 1'b0;
                  state_s = REQ;
               end else begin
                  state_s = HOLD;
               end
            end
            default: state_s = state_r;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r          <= REQ;
         fpc_r            <= RESET_PC;
         drop_r           <= 1'b0;
         instr            <= '0;
         instr_valid      <= 1'b0;
         pc               <= RESET_PC;
         pc_plus4         <= RESET_PC + WORD_STEP;
         misaligned_fault <= 1'b0;
      end else begin
         state_r          <= state_s;
         fpc_r            <= fpc_s;
         drop_r           <= drop_s;
         instr_valid      <= valid_s;
         misaligned_fault <= fault_s;
         if (load_s) begin
            instr    <= imem_rdata;
            pc       <= fpc_r;
            pc_plus4 <= fpc_r + WORD_STEP;
         end else begin
            instr    <= instr;
            pc       <= pc;
            pc_plus4 <= pc_plus4;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed cycle-table bench for instr_fetch: each row drives one cycle of inputs
// and lists the outputs expected during that cycle.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        en = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        id_ready = 1'b0;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        misaligned_fault;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        en, rdy, rv;
      logic [31:0] rdata;
      logic        redir;
      logic [31:0] rpc;
      logic        idr;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_val;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      logic        e_fault;
   } vec_t;

   instr_fetch #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rstn(rstn), .en(en),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
      .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
      .misaligned_fault(misaligned_fault)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic en_i, input logic rdy_i, input logic rv_i,
                               input logic [31:0] rdata_i, input logic redir_i,
                               input logic [31:0] rpc_i, input logic idr_i,
                               input logic e_req_i, input logic [31:0] e_addr_i,
                               input logic e_val_i, input logic [31:0] e_instr_i,
                               input logic [31:0] e_pc_i, input logic e_fault_i);
      vec_t v;
      v.en = en_i; v.rdy = rdy_i; v.rv = rv_i; v.rdata = rdata_i;
      v.redir = redir_i; v.rpc = rpc_i; v.idr = idr_i;
      v.e_req = e_req_i; v.e_addr = e_addr_i; v.e_val = e_val_i;
      v.e_instr = e_instr_i; v.e_pc = e_pc_i; v.e_fault = e_fault_i;
      return v;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
      end
   endtask

   task automatic check_outputs(input int row, input logic e_req, input logic [31:0] e_addr,
                                input logic e_val, input logic [31:0] e_instr,
                                input logic [31:0] e_pc, input logic e_fault);
      logic [31:0] e_pc4;
      e_pc4 = e_pc + 32'd4;
      chk("imem_req", row, {31'd0, imem_req}, {31'd0, e_req});
      chk("imem_addr", row, imem_addr, e_addr);
      chk("instr_valid", row, {31'd0, instr_valid}, {31'd0, e_val});
      chk("instr", row, instr, e_instr);
      chk("pc", row, pc, e_pc);
      chk("pc_plus4", row, pc_plus4, e_pc4);
      chk("misaligned_fault", row, {31'd0, misaligned_fault}, {31'd0, e_fault});
   endtask

   // Drive a row on the falling edge, check outputs before the next rising edge
   task automatic apply(input vec_t v, input int row);
      @(negedge clk);
      en = v.en; imem_ready = v.rdy; imem_rvalid = v.rv; imem_rdata = v.rdata;
      redirect = v.redir; redirect_pc = v.rpc; id_ready = v.idr;
      #1;
      check_outputs(row, v.e_req, v.e_addr, v.e_val, v.e_instr, v.e_pc, v.e_fault);
   endtask

   vec_t tbl[35];
   vec_t tail[5];

   initial begin
      // zero-wait fetches of 0 and 4
      tbl[0]  = mk(1,1,0,32'h0,0,32'h0,1,        1,32'h0,0,32'h0,32'h0,0);
      tbl[1]  = mk(1,1,1,32'hA5A5_0000,0,32'h0,1, 0,32'h0,0,32'h0,32'h0,0);
      tbl[2]  = mk(1,1,0,32'h0,0,32'h0,1,        0,32'h0,1,32'hA5A5_0000,32'h0,0);
      tbl[3]  = mk(1,1,0,32'h0,0,32'h0,1,        1,32'h4,0,32'hA5A5_0000,32'h0,0);
      tbl[4]  = mk(1,1,1,32'hA5A5_0004,0,32'h0,1, 0,32'h4,0,32'hA5A5_0000,32'h0,0);
      // decode stall for 5 cycles, then en low for one cycle
      for (int i = 5; i < 10; i++)
         tbl[i] = mk(1,1,0,32'h0,0,32'h0,0,      0,32'h4,1,32'hA5A5_0004,32'h4,0);
      tbl[10] = mk(0,1,0,32'h0,0,32'h0,1,        0,32'h4,1,32'hA5A5_0004,32'h4,0);
      tbl[11] = mk(1,1,0,32'h0,0,32'h0,1,        0,32'h4,1,32'hA5A5_0004,32'h4,0);
      // redirect to 0x200 while 0x8 is accepted: 0x8 response dropped
      tbl[12] = mk(1,1,0,32'h0,1,32'h200,1,      1,32'h8,0,32'hA5A5_0004,32'h4,0);
      tbl[13] = mk(1,1,1,32'hA5A5_0008,0,32'h0,1, 0,32'h200,0,32'hA5A5_0004,32'h4,0);
      tbl[14] = mk(1,1,0,32'h0,0,32'h0,1,        1,32'h200,0,32'hA5A5_0004,32'h4,0);
      tbl[15] = mk(1,1,1,32'hA5A5_0200,0,32'h0,1, 0,32'h200,0,32'hA5A5_0004,32'h4,0);
      tbl[16] = mk(1,1,0,32'h0,0,32'h0,1,        0,32'h200,1,32'hA5A5_0200,32'h200,0);
      // redirect to 0x100 during a 3-cycle memory wait
      tbl[17] = mk(1,1,0,32'h0,0,32'h0,1,        1,32'h204,0,32'hA5A5_0200,32'h200,0);
      tbl[18] = mk(1,1,0,32'h0,1,32'h100,1,      0,32'h204,0,32'hA5A5_0200,32'h200,0);
      tbl[19] = mk(1,1,0,32'h0,0,32'h0,1,        0,32'h100,0,32'hA5A5_0200,32'h200,0);
      tbl[20] = mk(1,1,1,32'hA5A5_0204,0,32'h0,1, 0,32'h100,0,32'hA5A5_0200,32'h200,0);
      tbl[21] = mk(1,1,0,32'h0,0,32'h0,1,        1,32'h100,0,32'hA5A5_0200,32'h200,0);
      tbl[22] = mk(1,1,1,32'hA5A5_0100,0,32'h0,1, 0,32'h100,0,32'hA5A5_0200,32'h200,0);
      tbl[23] = mk(1,1,0,32'h0,0,32'h0,1,        0,32'h100,1,32'hA5A5_0100,32'h100,0);
      // redirect to top word from REQ without accept, then wrap to 0
      tbl[24] = mk(1,0,0,32'h0,1,32'hFFFF_FFFC,1, 1,32'h104,0,32'hA5A5_0100,32'h100,0);
      tbl[25] = mk(1,1,0,32'h0,0,32'h0,1,        1,32'hFFFF_FFFC,0,32'hA5A5_0100,32'h100,0);
      tbl[26] = mk(1,1,1,32'h5A5A_FFFC,0,32'h0,1, 0,32'hFFFF_FFFC,0,32'hA5A5_0100,32'h100,0);
      tbl[27] = mk(1,1,0,32'h0,0,32'h0,1,        0,32'hFFFF_FFFC,1,32'h5A5A_FFFC,32'hFFFF_FFFC,0);
      tbl[28] = mk(0,1,0,32'h0,0,32'h0,1,        0,32'h0,0,32'h5A5A_FFFC,32'hFFFF_FFFC,0);
      tbl[29] = mk(1,0,0,32'h0,0,32'h0,1,        1,32'h0,0,32'h5A5A_FFFC,32'hFFFF_FFFC,0);
      // misaligned redirect on an accepted request: sticky fault, no more requests
      tbl[30] = mk(1,1,0,32'h0,1,32'h102,1,      1,32'h0,0,32'h5A5A_FFFC,32'hFFFF_FFFC,0);
      tbl[31] = mk(1,1,1,32'hDEAD_0000,0,32'h0,1, 0,32'h0,0,32'h5A5A_FFFC,32'hFFFF_FFFC,1);
      tbl[32] = mk(1,1,0,32'h0,0,32'h0,1,        0,32'h0,0,32'h5A5A_FFFC,32'hFFFF_FFFC,1);
      tbl[33] = mk(1,1,0,32'h0,0,32'h0,1,        0,32'h0,0,32'h5A5A_FFFC,32'hFFFF_FFFC,1);
      tbl[34] = mk(1,1,0,32'h0,1,32'h300,1,      0,32'h0,0,32'h5A5A_FFFC,32'hFFFF_FFFC,1);

      // after the second reset: stray response ignored, then a clean fetch of 0
      tail[0] = mk(1,0,1,32'h1234_5678,0,32'h0,1, 1,32'h0,0,32'h0,32'h0,0);
      tail[1] = mk(1,1,0,32'h0,0,32'h0,1,        1,32'h0,0,32'h0,32'h0,0);
      tail[2] = mk(1,1,1,32'hA5A5_0000,0,32'h0,1, 0,32'h0,0,32'h0,32'h0,0);
      tail[3] = mk(1,1,0,32'h0,0,32'h0,1,        0,32'h0,1,32'hA5A5_0000,32'h0,0);
      tail[4] = mk(1,0,0,32'h0,0,32'h0,1,        1,32'h4,0,32'hA5A5_0000,32'h0,0);

      // reset values while rstn is low, with en high
      #1 rstn = 1'b0;
      en = 1'b1;
      #2;
      check_outputs(-1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 35; i++)
         apply(tbl[i], i);

      // asynchronous reset away from the clock edge clears the sticky fault
      @(negedge clk);
      en = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0;
      #2 rstn = 1'b0;
      #1;
      check_outputs(-2, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 5; i++)
         apply(tail[i], 100 + i);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
